// File: rtl/pmem_arbiter_if.sv
// Port bundle for pmem_arbiter: fetch and data requesters plus the physical memory line port.
// The slave modport is the arbiter's view; master is the core/memory side that surrounds it.
interface pmem_arbiter_if;
  logic         imem_read;
  logic [15:0]  imem_address;
  logic         imem_resp;
  logic [127:0] imem_rdata;

  logic         dmem_read;
  logic         dmem_write;
  logic [15:0]  dmem_address;
  logic [127:0] dmem_wdata;
  logic         dmem_resp;
  logic [127:0] dmem_rdata;

  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  modport slave (
    input  imem_read, imem_address, dmem_read, dmem_write, dmem_address, dmem_wdata,
           pmem_resp, pmem_rdata,
    output imem_resp, imem_rdata, dmem_resp, dmem_rdata,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output imem_read, imem_address, dmem_read, dmem_write, dmem_address, dmem_wdata,
           pmem_resp, pmem_rdata,
    input  imem_resp, imem_rdata, dmem_resp, dmem_rdata,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares one physical memory line port between fetch (imem) and data (dmem) requesters.
// Define ARB_ROUND_ROBIN_EN for alternating grants; default is dmem priority with a starvation limit.
module pmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pmem_arbiter_if.slave bus,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    // Handshake: each requester holds its strobe until its one-cycle resp; pmem strobes are
    // held from the latched op until pmem_resp, and resp is only routed to the granted side.
    state_e         state_q, state_d;
    logic [15:0]    addr_q, addr_d;
    logic [127:0]   wdata_q, wdata_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic           imem_req, dmem_req, imem_wins;

`ifdef ARB_ROUND_ROBIN_EN
    logic           last_d_q, last_d_d;

    assign imem_wins = last_d_q;
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0]     starve_cnt_q, starve_cnt_d;

    assign imem_wins = (starve_cnt_q == LIMIT);
`endif

    assign imem_req = bus.imem_read;
    assign dmem_req = bus.dmem_read | bus.dmem_write;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d = last_d_q;
`else
        starve_cnt_d = starve_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (dmem_req && !(imem_req && imem_wins)) begin
                    state_d = SERVE_D;
                    addr_d  = bus.dmem_address;
                    wdata_d = bus.dmem_wdata;
                    // A simultaneous read+write is resolved as a write.
                    wr_d    = bus.dmem_write;
                    rd_d    = ~bus.dmem_write;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b1;
`else
                    if (imem_req && (starve_cnt_q < LIMIT)) starve_cnt_d = starve_cnt_q + 4'd1;
`endif
                end else if (imem_req) begin
                    state_d = SERVE_I;
                    addr_d  = bus.imem_address;
                    wdata_d = '0;
                    rd_d    = 1'b1;
                    wr_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b0;
`else
                    starve_cnt_d = '0;
`endif
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    wdata_d = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b0;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= last_d_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    assign bus.pmem_read    = rd_q;
    assign bus.pmem_write   = wr_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.imem_resp    = (state_q == SERVE_I) & bus.pmem_resp;
    assign bus.dmem_resp    = (state_q == SERVE_D) & bus.pmem_resp;
    assign bus.imem_rdata   = bus.pmem_rdata;
    assign bus.dmem_rdata   = bus.pmem_rdata;
    assign state_dbg        = state_q;

    a_no_rw_conflict: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.dmem_read && bus.dmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: reset, lone fetch, write hold, grant order and mid-op reset.
module tb_pmem_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [0:0] exp_q[$];

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] WDATA_X = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  pmem_arbiter_if bus();

  pmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_read    = 1'b0;
    bus.imem_address = 16'h0;
    bus.dmem_read    = 1'b0;
    bus.dmem_write   = 1'b0;
    bus.dmem_address = 16'h0;
    bus.dmem_wdata   = '0;
    bus.pmem_resp    = 1'b0;
    bus.pmem_rdata   = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.imem_read    = 1'b1;
    bus.imem_address = 16'h1110;
    bus.dmem_read    = 1'b1;
    bus.dmem_address = 16'h2220;
    bus.dmem_wdata   = WDATA_X;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bus.pmem_read, bus.pmem_write, bus.imem_resp, bus.dmem_resp, state_dbg} !== 6'b0 ||
          bus.pmem_address !== 16'h0 || bus.pmem_wdata !== 128'h0 ||
          bus.imem_rdata !== 128'h0 || bus.dmem_rdata !== 128'h0) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: rd=%b wr=%b iresp=%b dresp=%b st=%0d addr=%h expected all 0",
                 i, bus.pmem_read, bus.pmem_write, bus.imem_resp, bus.dmem_resp, state_dbg, bus.pmem_address);
      end
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.pmem_read !== 1'b1 || state_dbg !== 2'd2 || bus.pmem_address !== 16'h2220) begin
      n_err++;
      $display("FAIL reset_first_grant: rd=%b st=%0d addr=%h expected rd=1 st=2 addr=2220",
               bus.pmem_read, state_dbg, bus.pmem_address);
    end
    bus.pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if (bus.dmem_resp !== 1'b1 || bus.imem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_resp: dresp=%b iresp=%b expected 1/0", bus.dmem_resp, bus.imem_resp);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_lone_fetch();
    int pulses;
    do_reset();
    bus.imem_read    = 1'b1;
    bus.imem_address = 16'h1230;
    pulses = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 5) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = LINE_A5;
        #1;
      end
      n_cmp++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_address !== 16'h1230) begin
        n_err++;
        $display("FAIL fetch_strobe cycle %0d: rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=1230",
                 c, bus.pmem_read, bus.pmem_write, bus.pmem_address);
      end
      if (bus.imem_resp === 1'b1) pulses++;
    end
    n_cmp++;
    if (bus.imem_rdata !== LINE_A5 || bus.dmem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_data: rdata=%h dresp=%b expected %h dresp=0", bus.imem_rdata, bus.dmem_resp, LINE_A5);
    end
    tick();
    bus.imem_read = 1'b0;
    bus.pmem_resp = 1'b0;
    #1;
    if (bus.imem_resp === 1'b1) pulses++;
    n_cmp++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL fetch_resp_pulses: got %0d expected 1", pulses);
    end
    n_cmp++;
    if (bus.pmem_read !== 1'b0 || state_dbg !== 2'd0 || bus.pmem_address !== 16'h0) begin
      n_err++;
      $display("FAIL fetch_back_idle: rd=%b st=%0d addr=%h expected 0/0/0", bus.pmem_read, state_dbg, bus.pmem_address);
    end
    // A stray pmem_resp while idle must not produce any response.
    bus.pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if (bus.imem_resp !== 1'b0 || bus.dmem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL idle_resp_ignored: iresp=%b dresp=%b expected 0/0", bus.imem_resp, bus.dmem_resp);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if (state_dbg !== 2'd0 || bus.pmem_read !== 1'b0) begin
      n_err++;
      $display("FAIL idle_resp_state: st=%0d rd=%b expected 0/0", state_dbg, bus.pmem_read);
    end
  endtask

  task automatic test_write_hold();
    do_reset();
    bus.dmem_write   = 1'b1;
    bus.dmem_address = 16'h4000;
    bus.dmem_wdata   = WDATA_X;
    tick();
    n_cmp++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_wdata !== WDATA_X ||
        bus.pmem_address !== 16'h4000) begin
      n_err++;
      $display("FAIL write_start: wr=%b rd=%b addr=%h wdata=%h expected 1/0/4000/%h",
               bus.pmem_write, bus.pmem_read, bus.pmem_address, bus.pmem_wdata, WDATA_X);
    end
    bus.dmem_wdata   = ~WDATA_X;
    bus.dmem_address = 16'h5550;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (bus.pmem_wdata !== WDATA_X || bus.pmem_address !== 16'h4000 || bus.pmem_write !== 1'b1) begin
        n_err++;
        $display("FAIL write_hold cycle %0d: addr=%h wdata=%h expected 4000/%h",
                 c, bus.pmem_address, bus.pmem_wdata, WDATA_X);
      end
    end
    bus.pmem_resp = 1'b1;
    #1;
    n_cmp++;
    if (bus.dmem_resp !== 1'b1 || bus.imem_resp !== 1'b0 || bus.pmem_wdata !== WDATA_X) begin
      n_err++;
      $display("FAIL write_resp: dresp=%b iresp=%b wdata=%h expected 1/0/%h",
               bus.dmem_resp, bus.imem_resp, bus.pmem_wdata, WDATA_X);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_grant_order();
    logic [0:0] exp_g;
    logic [0:0] got_g;
    int         waited;
`ifdef ARB_ROUND_ROBIN_EN
    logic [9:0] order = 10'b0101010101;
`else
    logic [9:0] order = 10'b0111101111;
`endif
    for (int i = 0; i < 10; i++) exp_q.push_back(order[i]);
    do_reset();
    bus.imem_read    = 1'b1;
    bus.imem_address = 16'h1110;
    bus.dmem_read    = 1'b1;
    bus.dmem_address = 16'h2220;
    for (int g = 0; g < 10; g++) begin
      waited = 0;
      while (bus.pmem_read !== 1'b1 && waited < 5) begin
        tick();
        waited++;
      end
      exp_g = exp_q.pop_front();
      got_g = (state_dbg == 2'd2) ? 1'b1 : 1'b0;
      n_cmp++;
      if (waited !== 1) begin
        n_err++;
        $display("FAIL grant_latency #%0d: waited %0d cycles expected 1", g, waited);
        break;
      end
      n_cmp++;
      if (got_g !== exp_g || bus.pmem_address !== (exp_g ? 16'h2220 : 16'h1110)) begin
        n_err++;
        $display("FAIL grant_order #%0d: got %s addr=%h expected %s", g,
                 got_g ? "D" : "I", bus.pmem_address, exp_g ? "D" : "I");
      end
      bus.pmem_resp = 1'b1;
      #1;
      n_cmp++;
      if (bus.dmem_resp !== exp_g || bus.imem_resp !== ~exp_g) begin
        n_err++;
        $display("FAIL grant_resp #%0d: dresp=%b iresp=%b expected %b/%b",
                 g, bus.dmem_resp, bus.imem_resp, exp_g, ~exp_g);
      end
      tick();
      bus.pmem_resp = 1'b0;
    end
    exp_q.delete();
    idle_inputs();
    tick();
  endtask

  task automatic test_mid_op_reset();
    do_reset();
    bus.dmem_read    = 1'b1;
    bus.dmem_address = 16'h3330;
    tick();
    tick();
    n_cmp++;
    if (state_dbg !== 2'd2 || bus.pmem_read !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_serving: st=%0d rd=%b expected 2/1", state_dbg, bus.pmem_read);
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (state_dbg !== 2'd0 || bus.pmem_read !== 1'b0 || bus.pmem_address !== 16'h0) begin
      n_err++;
      $display("FAIL midreset_drop: st=%0d rd=%b addr=%h expected 0/0/0", state_dbg, bus.pmem_read, bus.pmem_address);
    end
    rst_n = 1'b1;
    bus.dmem_read  = 1'b0;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 128'h1;
    #1;
    n_cmp++;
    if (bus.dmem_resp !== 1'b0 || bus.imem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_late_resp: dresp=%b iresp=%b expected 0/0", bus.dmem_resp, bus.imem_resp);
    end
    tick();
    bus.pmem_resp = 1'b0;
    n_cmp++;
    if (state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL midreset_idle: st=%0d expected 0", state_dbg);
    end
    bus.dmem_read    = 1'b1;
    bus.dmem_address = 16'h3340;
    tick();
    n_cmp++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h3340) begin
      n_err++;
      $display("FAIL midreset_next_req: rd=%b addr=%h expected 1/3340", bus.pmem_read, bus.pmem_address);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = LINE_A5;
    #1;
    n_cmp++;
    if (bus.dmem_resp !== 1'b1 || bus.dmem_rdata !== LINE_A5 || bus.imem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_next_resp: dresp=%b rdata=%h iresp=%b expected 1/%h/0",
               bus.dmem_resp, bus.dmem_rdata, bus.imem_resp, LINE_A5);
    end
    tick();
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_lone_fetch();
    test_write_hold();
    test_grant_order();
    test_mid_op_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
